// File: rtl/burst_ram_arbiter.sv
`default_nettype none
// =============================================================================
// burst_ram_arbiter: shares one BurstRAM port between port 0 (I-cache) and port 1 (D-cache).
// Option macro BURST_RAM_ARBITER_FIXED_PRIORITY_EN: port 1 always wins ties. Rev 1.0
// =============================================================================
module burst_ram_arbiter #(
  parameter int RAM_BURST_DATA_COUNT    = 4,
  parameter int RAM_BURST_DATA_BITWIDTH = 64,
  parameter int RAM_DEPTH_BITWIDTH      = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  // port 0
  input  logic                                   p0_cmd,
  input  logic                                   p0_cmd_en,
  input  logic [RAM_DEPTH_BITWIDTH-1:0]          p0_addr,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]     p0_wr_data,
  input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0]   p0_data_mask,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]     p0_rd_data,
  output logic                                   p0_rd_data_valid,
  output logic                                   p0_busy,
  // port 1
  input  logic                                   p1_cmd,
  input  logic                                   p1_cmd_en,
  input  logic [RAM_DEPTH_BITWIDTH-1:0]          p1_addr,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]     p1_wr_data,
  input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0]   p1_data_mask,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]     p1_rd_data,
  output logic                                   p1_rd_data_valid,
  output logic                                   p1_busy,
  // shared BurstRAM
  output logic                                   br_cmd,
  output logic                                   br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0]          br_addr,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]     br_wr_data,
  output logic [RAM_BURST_DATA_BITWIDTH/8-1:0]   br_data_mask,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]     br_rd_data,
  input  logic                                   br_rd_data_valid,
  input  logic                                   br_busy
);

  localparam int AW = RAM_DEPTH_BITWIDTH;
  localparam int DW = RAM_BURST_DATA_BITWIDTH;
  localparam int MW = RAM_BURST_DATA_BITWIDTH / 8;
  localparam int BW = $clog2(RAM_BURST_DATA_COUNT);
  localparam logic [BW-1:0] LAST_BEAT = BW'(RAM_BURST_DATA_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_DATA = 2'd1,
    READ_WAIT  = 2'd2
  } state_t;

  state_t        state, state_next;
  logic          owner, owner_next;
  logic [BW-1:0] beat, beat_next;

  logic [1:0]    port_cmd, port_cmd_en;
  logic [AW-1:0] port_addr    [2];
  logic [DW-1:0] port_wr_data [2];
  logic [MW-1:0] port_mask    [2];

  logic [1:0]    req, head_cmd, pop, line_release, fwd, ret_valid, busy;
  logic [AW-1:0] head_addr [2];
  logic [MW-1:0] head_mask [2];
  logic [DW-1:0] line_beat [2];
  logic [DW-1:0] ret_data  [2];
  logic [BW-1:0] line_sel;
  logic          grant_port, grant_fire;

  assign port_cmd        = {p1_cmd, p0_cmd};
  assign port_cmd_en     = {p1_cmd_en, p0_cmd_en};
  assign port_addr[0]    = p0_addr;
  assign port_addr[1]    = p1_addr;
  assign port_wr_data[0] = p0_wr_data;
  assign port_wr_data[1] = p1_wr_data;
  assign port_mask[0]    = p0_data_mask;
  assign port_mask[1]    = p1_data_mask;

  // Beat 0 is replayed in the grant cycle, later beats follow the burst counter.
  assign line_sel   = (state == IDLE) ? '0 : beat;
  assign grant_fire = (state == IDLE) && !rst && !br_busy && (req != 2'b00);

`ifdef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
  assign grant_port = req[1];
`else
  logic last_grant;

  assign grant_port = (req == 2'b11) ? ~last_grant : req[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (grant_fire) begin
      last_grant <= grant_port;
    end
  end
`endif

  for (genvar n = 0; n < 2; n++) begin : g_port
    logic          fifo_cmd  [2];
    logic [AW-1:0] fifo_addr [2];
    logic [MW-1:0] fifo_mask [2];
    logic          wr_ptr, rd_ptr;
    logic [1:0]    count;
    logic [DW-1:0] line [RAM_BURST_DATA_COUNT];
    logic          line_busy, capturing;
    logic [BW-1:0] cap_idx;
    logic          accept, accept_write;
    logic [DW-1:0] data_reg;
    logic          valid_reg;

    // A write also needs the line buffer, otherwise the command is dropped.
    assign accept       = port_cmd_en[n] && (count != 2'd2) && !(port_cmd[n] && line_busy);
    assign accept_write = accept && port_cmd[n];

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (accept) begin
          fifo_cmd[wr_ptr]  <= port_cmd[n];
          fifo_addr[wr_ptr] <= port_addr[n];
          fifo_mask[wr_ptr] <= port_mask[n];
          wr_ptr            <= ~wr_ptr;
        end
        if (pop[n]) begin
          rd_ptr <= ~rd_ptr;
        end
        case ({accept, pop[n]})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        line_busy <= 1'b0;
        capturing <= 1'b0;
        cap_idx   <= '0;
      end else begin
        if (accept_write) begin
          line[0]   <= port_wr_data[n];
          line_busy <= 1'b1;
          capturing <= 1'b1;
          cap_idx   <= BW'(1);
        end else if (capturing) begin
          line[cap_idx] <= port_wr_data[n];
          cap_idx       <= cap_idx + 1'b1;
          if (cap_idx == LAST_BEAT) begin
            capturing <= 1'b0;
          end
        end
        if (line_release[n]) begin
          line_busy <= 1'b0;
        end
      end
    end

    assign fwd[n] = (state == READ_WAIT) && br_rd_data_valid && (owner == 1'(n));

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
      end else begin
        valid_reg <= fwd[n];
        if (fwd[n]) begin
          data_reg <= br_rd_data;
        end
      end
    end

    assign req[n]       = (count != 2'd0);
    assign head_cmd[n]  = fifo_cmd[rd_ptr];
    assign head_addr[n] = fifo_addr[rd_ptr];
    assign head_mask[n] = fifo_mask[rd_ptr];
    assign line_beat[n] = line[line_sel];
    assign ret_valid[n] = valid_reg;
    assign ret_data[n]  = data_reg;
    assign busy[n]      = req[n] || line_busy || ((state != IDLE) && (owner == 1'(n)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      beat  <= '0;
    end else begin
      state <= state_next;
      owner <= owner_next;
      beat  <= beat_next;
    end
  end

  always_comb begin
    state_next   = state;
    owner_next   = owner;
    beat_next    = beat;
    pop          = '0;
    line_release = '0;
    br_cmd       = 1'b0;
    br_cmd_en    = 1'b0;
    br_addr      = '0;
    br_wr_data   = '0;
    br_data_mask = '0;
    case (state)
      IDLE: begin
        if (grant_fire) begin
          pop[grant_port] = 1'b1;
          br_cmd_en       = 1'b1;
          br_cmd          = head_cmd[grant_port];
          br_addr         = head_addr[grant_port];
          br_data_mask    = head_mask[grant_port];
          owner_next      = grant_port;
          if (head_cmd[grant_port]) begin
            br_wr_data = line_beat[grant_port];
            beat_next  = BW'(1);
            state_next = WRITE_DATA;
          end else begin
            beat_next  = '0;
            state_next = READ_WAIT;
          end
        end
      end
      WRITE_DATA: begin
        br_wr_data = line_beat[owner];
        if (beat == LAST_BEAT) begin
          line_release[owner] = 1'b1;
          beat_next           = '0;
          state_next          = IDLE;
        end else begin
          beat_next = beat + 1'b1;
        end
      end
      READ_WAIT: begin
        if (br_rd_data_valid) begin
          if (beat == LAST_BEAT) begin
            beat_next  = '0;
            state_next = IDLE;
          end else begin
            beat_next = beat + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign p0_rd_data       = ret_data[0];
  assign p0_rd_data_valid = ret_valid[0];
  assign p0_busy          = busy[0];
  assign p1_rd_data       = ret_data[1];
  assign p1_rd_data_valid = ret_valid[1];
  assign p1_busy          = busy[1];

endmodule
`default_nettype wire
